// File: rtl/cyclic_decoder_checker.sv
// Serial cyclic-code receive checker.
// Divides each 16-bit frame (12 data bits then 4 check bits, MSB first) by
// g(x) = x^4 + x + 1. It presents the data bits, the syndrome, an error flag
// and a saturating count of bad frames. This block only detects errors; it does
// not correct them.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   enable      bit qualifier; low aborts any partial frame
//   in          serial codeword bit
//   data_out    data bits of last completed frame (MSB = first received)
//   syndrome    remainder of last completed frame mod g(x)
//   frame_valid one-cycle pulse when the frame outputs update
//   frame_err   syndrome of last completed frame is nonzero
//   err_count   saturating number of bad frames since reset
module cyclic_decoder_checker #(
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned CHECK_BITS = 4,
  parameter logic [CHECK_BITS-1:0] POLY = 4'b0011,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in,
  output logic [DATA_BITS-1:0]  data_out,
  output logic [CHECK_BITS-1:0] syndrome,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam int unsigned N     = DATA_BITS + CHECK_BITS;
  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_BITS);

  logic [CNT_W-1:0]      bit_cnt;
  logic [CHECK_BITS-1:0] rem;
  logic [DATA_BITS-1:0]  data_sr;

  logic [CHECK_BITS-1:0] rem_next_c;
  logic                  last_bit_c;
  logic                  in_data_c;
  logic                  err_sat_c;

  // One step of polynomial long division, plus frame-position decodes.
  always_comb begin
    rem_next_c = {rem[CHECK_BITS-2:0], in};
    if (rem[CHECK_BITS-1]) begin
      rem_next_c = rem_next_c ^ POLY;
    end
    last_bit_c = (bit_cnt == LAST_BIT);
    in_data_c  = (bit_cnt < DATA_END);
    err_sat_c  = &err_count;
  end

  // Frame accumulation and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rem         <= '0;
      data_sr     <= '0;
      data_out    <= '0;
      syndrome    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (!enable) begin
        // Abort: discard the partial frame; the next enabled bit is bit 0.
        bit_cnt <= '0;
        rem     <= '0;
        data_sr <= '0;
      end else if (last_bit_c) begin
        bit_cnt     <= '0;
        rem         <= '0;
        data_sr     <= '0;
        data_out    <= data_sr;
        syndrome    <= rem_next_c;
        frame_err   <= |rem_next_c;
        frame_valid <= 1'b1;
        if ((|rem_next_c) && !err_sat_c) begin
          err_count <= err_count + ERRCNT_W'(1);
        end
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        rem     <= rem_next_c;
        if (in_data_c) begin
          data_sr <= {data_sr[DATA_BITS-2:0], in};
        end
      end
    end
  end

endmodule

// File: tb/tb_cyclic_decoder_checker.sv
// Scoreboard bench for cyclic_decoder_checker: stimulus pushes the expected
// frame results, and a negedge monitor pops and compares them on each frame_valid.
module tb_cyclic_decoder_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in;
  logic [11:0] data_out;
  logic [3:0]  syndrome;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_count;

  typedef struct {
    logic [11:0] data;
    logic [3:0]  syn;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pulse = -1;
  int   prev_pulse = -1;
  logic [7:0] model_cnt = 8'd0;

  cyclic_decoder_checker dut (
    .clk(clk), .rst(rst), .enable(enable), .in(in),
    .data_out(data_out), .syndrome(syndrome), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every frame_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst !== 1'b1 && frame_valid === 1'b1) begin
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("syndrome", 32'(syndrome), 32'(e.syn));
        check("frame_err", 32'(frame_err), 32'(e.err));
        check("err_count", 32'(err_count), 32'(e.cnt));
      end
    end
  end

  // Record the expected outcome of a frame whose data and syndrome were worked out by hand.
  task automatic expect_frame(input logic [11:0] d, input logic [3:0] s);
    exp_t e;
    if (s != 4'h0 && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    e.data = d;
    e.syn  = s;
    e.err  = (s != 4'h0);
    e.cnt  = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [15:0] cw, input int nbits, input bit keep_en);
    for (int i = 15; i > 15 - nbits; i--) begin
      enable = 1'b1;
      in     = cw[i];
      @(posedge clk);
      #1;
    end
    if (!keep_en) begin
      enable = 1'b0;
      in     = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] cw, input logic [11:0] d,
                            input logic [3:0] s, input bit keep_en);
    expect_frame(d, s);
    send_bits(cw, 16, keep_en);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = 8'd0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    in = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_syndrome", 32'(syndrome), 32'd0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;

    // All-zero frame, then single clean and corrupted codewords.
    send_frame(16'h0000, 12'h000, 4'h0, 1'b0);
    drain("drain_zero");
    send_frame(16'h0013, 12'h001, 4'h0, 1'b0);
    drain("drain_0013");
    send_frame(16'h8001, 12'h800, 4'h0, 1'b0);
    drain("drain_8001");
    send_frame(16'h0001, 12'h000, 4'h1, 1'b0);
    drain("drain_0001");
    send_frame(16'h0003, 12'h000, 4'h3, 1'b0);
    drain("drain_0003");

    // Back-to-back frames, enable held high throughout.
    send_frame(16'h0013, 12'h001, 4'h0, 1'b1);
    send_frame(16'h8001, 12'h800, 4'h0, 1'b0);
    drain("drain_b2b");
    check("b2b_pulse_spacing", 32'(last_pulse - prev_pulse), 32'd16);

    // Abort after 7 bits: nothing expected, then a full frame decodes cleanly.
    send_bits(16'h0001, 7, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    send_frame(16'h0013, 12'h001, 4'h0, 1'b0);
    drain("drain_after_abort");

    // Reset in the middle of a frame clears err_count.
    send_bits(16'hFFFF, 9, 1'b0);
    do_reset();
    @(negedge clk);
    check("midreset_err_count", 32'(err_count), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_data_out", 32'(data_out), 32'd0);
    @(posedge clk);
    #1;
    send_frame(16'h0013, 12'h001, 4'h0, 1'b0);
    drain("drain_after_midreset");

    // Saturation: 300 corrupted frames back to back.
    for (int k = 0; k < 300; k++) begin
      if (k[0]) send_frame(16'h0003, 12'h000, 4'h3, 1'b1);
      else      send_frame(16'h0001, 12'h000, 4'h1, 1'b1);
    end
    enable = 1'b0;
    drain("drain_saturation");
    check("sat_err_count", 32'(err_count), 32'hFF);

    // A clean frame after saturation leaves the count pinned.
    send_frame(16'h8001, 12'h800, 4'h0, 1'b0);
    drain("drain_post_sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
